multicycle_control: RTL and testbench

Multi-cycle MIPS main controller: a Moore FSM that sequences each instruction over 3–5+ cycles through a shared memory port and ALU, replacing the single-cycle combinational decoder. It adds a memory-ready handshake, a parametrised minimum memory wait, an illegal-opcode trap, and a visible state code. It sits between the instruction register (op/funct) and the multi-cycle datapath muxes, write enables and PC logic.

---
 rtl/multicycle_control.sv | 203 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: Moore sequencer driving the shared-memory datapath,
// with a memory-ready handshake, minimum memory wait and an illegal-opcode trap.
module multicycle_control #(
  parameter int MEM_WAIT = 0,
  parameter bit TRAP_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond_eq,
  output logic       pc_write_cond_ne,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [1:0] reg_dest,
  output logic [1:0] mem_to_reg,
  output logic       illegal,
  output logic [3:0] state
);
  // state  | meaning
  // FETCH  | read instruction, PC+4 (memory state)
  // DECODE | register read, branch target in ALUOut
  // MEMADR | lw/sw effective address
  // MEMRD  | data read (memory state)
  // MEMWB  | load write-back
  // MEMWR  | data write (memory state)
  // EXEC   | R-type ALU operation
  // RWB    | R-type write-back
  // ADDIEX | addi ALU operation
  // ADDIWB | addi write-back
  // BRANCH | beq/bne compare and conditional PC write
  // JUMP   | j/jal, jal links $31
  // JR     | PC <- regA
  // TRAP   | unknown opcode, held until reset
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_JR     = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // A zero wait still needs a 1-bit counter so the compare stays well formed.
  localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(MEM_WAIT);

  logic [3:0]    state_q;
  logic [3:0]    state_d;
  logic [CW-1:0] wait_cnt;
  logic          mem_state;
  logic          mem_done;

  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign mem_done  = mem_state && (wait_cnt == WAIT_MAX) && mem_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_done) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_RTYPE:        state_d = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_ADDI:         state_d = S_ADDIEX;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J, OP_JAL:    state_d = S_JUMP;
          default:         state_d = TRAP_EN ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_done) state_d = S_MEMWB;
      S_MEMWR:  if (mem_done) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        wait_cnt <= '0;
      else if (mem_state && (wait_cnt != WAIT_MAX))
        wait_cnt <= wait_cnt + CW'(1);
    end
  end

  always_comb begin
    pc_write         = 1'b0;
    pc_write_cond_eq = 1'b0;
    pc_write_cond_ne = 1'b0;
    ir_write         = 1'b0;
    reg_write        = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    i_or_d           = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'd0;
    alu_op           = 2'b00;
    pc_source        = 2'd0;
    reg_dest         = 2'd0;
    mem_to_reg       = 2'd0;
    illegal          = 1'b0;
    if (reset) begin
      alu_src_b = 2'd1;
    end else begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_done;
          pc_write  = mem_done;
        end
        S_DECODE: alu_src_b = 2'd3;
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEMRD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        S_MEMWR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_RWB: begin
          reg_write = 1'b1;
          reg_dest  = 2'd1;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_ADDIWB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a        = 1'b1;
          alu_op           = 2'b01;
          pc_source        = 2'd1;
          pc_write_cond_eq = (op == OP_BEQ);
          pc_write_cond_ne = (op == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          if (op == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dest   = 2'd2;
            mem_to_reg = 2'd2;
          end
        end
        S_JR: begin
          pc_write  = 1'b1;
          pc_source = 2'd3;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three instances cover MEM_WAIT=0/2 and TRAP_EN=1/0.
module tb_multicycle_control;
  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       mem_ready;

  logic       pc_write [3];
  logic       cond_eq  [3];
  logic       cond_ne  [3];
  logic       ir_write [3];
  logic       reg_write[3];
  logic       mem_read [3];
  logic       mem_write[3];
  logic       i_or_d   [3];
  logic       alu_src_a[3];
  logic [1:0] alu_src_b[3];
  logic [1:0] alu_op   [3];
  logic [1:0] pc_source[3];
  logic [1:0] reg_dest [3];
  logic [1:0] mem_to_reg[3];
  logic       illegal  [3];
  logic [3:0] st       [3];
  logic [19:0] ctl     [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT(0), .TRAP_EN(1'b1)) u_w0 (
    .clk(clk), .reset(rst[0]), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write[0]), .pc_write_cond_eq(cond_eq[0]), .pc_write_cond_ne(cond_ne[0]),
    .ir_write(ir_write[0]), .reg_write(reg_write[0]), .mem_read(mem_read[0]),
    .mem_write(mem_write[0]), .i_or_d(i_or_d[0]), .alu_src_a(alu_src_a[0]),
    .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]), .pc_source(pc_source[0]),
    .reg_dest(reg_dest[0]), .mem_to_reg(mem_to_reg[0]), .illegal(illegal[0]), .state(st[0]));

  multicycle_control #(.MEM_WAIT(2), .TRAP_EN(1'b1)) u_w2 (
    .clk(clk), .reset(rst[1]), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write[1]), .pc_write_cond_eq(cond_eq[1]), .pc_write_cond_ne(cond_ne[1]),
    .ir_write(ir_write[1]), .reg_write(reg_write[1]), .mem_read(mem_read[1]),
    .mem_write(mem_write[1]), .i_or_d(i_or_d[1]), .alu_src_a(alu_src_a[1]),
    .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]), .pc_source(pc_source[1]),
    .reg_dest(reg_dest[1]), .mem_to_reg(mem_to_reg[1]), .illegal(illegal[1]), .state(st[1]));

  multicycle_control #(.MEM_WAIT(0), .TRAP_EN(1'b0)) u_nt (
    .clk(clk), .reset(rst[2]), .op(op), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write[2]), .pc_write_cond_eq(cond_eq[2]), .pc_write_cond_ne(cond_ne[2]),
    .ir_write(ir_write[2]), .reg_write(reg_write[2]), .mem_read(mem_read[2]),
    .mem_write(mem_write[2]), .i_or_d(i_or_d[2]), .alu_src_a(alu_src_a[2]),
    .alu_src_b(alu_src_b[2]), .alu_op(alu_op[2]), .pc_source(pc_source[2]),
    .reg_dest(reg_dest[2]), .mem_to_reg(mem_to_reg[2]), .illegal(illegal[2]), .state(st[2]));

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign ctl[g] = {pc_write[g], cond_eq[g], cond_ne[g], ir_write[g], reg_write[g],
                     mem_read[g], mem_write[g], i_or_d[g], alu_src_a[g], alu_src_b[g],
                     alu_op[g], pc_source[g], reg_dest[g], mem_to_reg[g], illegal[g]};
  end

  // {pcw,ceq,cne,irw,rw,mr,mw,iord,asa}, alu_src_b, alu_op, pc_source, reg_dest, mem_to_reg, illegal
  localparam logic [19:0] C_RESET      = {9'b000000000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_FETCH_WAIT = {9'b000001000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_FETCH_DONE = {9'b100101000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_DECODE     = {9'b000000000, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_MEMADR     = {9'b000000001, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_MEMRD      = {9'b000001010, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_MEMWB      = {9'b000010000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0};
  localparam logic [19:0] C_MEMWR      = {9'b000000110, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_EXEC       = {9'b000000001, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_RWB        = {9'b000010000, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b0};
  localparam logic [19:0] C_ADDIEX     = {9'b000000001, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_ADDIWB     = {9'b000010000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_BEQ        = {9'b010000001, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_BNE        = {9'b001000001, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_J          = {9'b100000000, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_JAL        = {9'b100010000, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 1'b0};
  localparam logic [19:0] C_JR         = {9'b100000000, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 1'b0};
  localparam logic [19:0] C_TRAP       = {9'b000000000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1};

  // Compare one instance mid-cycle, then advance to just after the next rising edge.
  task automatic step(input int d, input string tag, input logic [3:0] es, input logic [19:0] ec);
    @(negedge clk);
    checks++;
    assert ({st[d], ctl[d]} === {es, ec}) else begin
      errors++;
      $error("FAIL %s: observed state=%0d ctl=%05h, expected state=%0d ctl=%05h",
             tag, st[d], ctl[d], es, ec);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 3'b111;
    op = 6'b000000;
    funct = 6'b100000;
    mem_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;

    // reset state of the MEM_WAIT=0 instance
    step(0, "reset", 4'd0, C_RESET);
    rst[0] = 1'b0;

    op = 6'b100011;
    step(0, "lw_fetch", 4'd0, C_FETCH_DONE);
    step(0, "lw_decode", 4'd1, C_DECODE);
    step(0, "lw_memadr", 4'd2, C_MEMADR);
    step(0, "lw_memrd", 4'd3, C_MEMRD);
    step(0, "lw_memwb", 4'd4, C_MEMWB);

    op = 6'b101011;
    step(0, "sw_fetch", 4'd0, C_FETCH_DONE);
    step(0, "sw_decode", 4'd1, C_DECODE);
    step(0, "sw_memadr", 4'd2, C_MEMADR);
    step(0, "sw_memwr", 4'd5, C_MEMWR);

    op = 6'b000000; funct = 6'b100000;
    step(0, "r_fetch", 4'd0, C_FETCH_DONE);
    mem_ready = 1'b0;
    step(0, "r_decode", 4'd1, C_DECODE);
    step(0, "r_exec", 4'd6, C_EXEC);
    step(0, "r_rwb", 4'd7, C_RWB);
    mem_ready = 1'b1;

    op = 6'b001000;
    step(0, "addi_fetch", 4'd0, C_FETCH_DONE);
    step(0, "addi_decode", 4'd1, C_DECODE);
    step(0, "addi_ex", 4'd8, C_ADDIEX);
    step(0, "addi_wb", 4'd9, C_ADDIWB);

    op = 6'b000100;
    step(0, "beq_fetch", 4'd0, C_FETCH_DONE);
    step(0, "beq_decode", 4'd1, C_DECODE);
    step(0, "beq_branch", 4'd10, C_BEQ);
    op = 6'b000101;
    step(0, "bne_fetch", 4'd0, C_FETCH_DONE);
    step(0, "bne_decode", 4'd1, C_DECODE);
    step(0, "bne_branch", 4'd10, C_BNE);

    op = 6'b000010;
    step(0, "j_fetch", 4'd0, C_FETCH_DONE);
    step(0, "j_decode", 4'd1, C_DECODE);
    step(0, "j_jump", 4'd11, C_J);
    op = 6'b000011;
    step(0, "jal_fetch", 4'd0, C_FETCH_DONE);
    step(0, "jal_decode", 4'd1, C_DECODE);
    step(0, "jal_jump", 4'd11, C_JAL);
    op = 6'b000000; funct = 6'b001000;
    step(0, "jr_fetch", 4'd0, C_FETCH_DONE);
    step(0, "jr_decode", 4'd1, C_DECODE);
    step(0, "jr_jr", 4'd12, C_JR);

    // reset lands in the middle of a stalled store
    op = 6'b101011; funct = 6'b100000;
    step(0, "swr_fetch", 4'd0, C_FETCH_DONE);
    step(0, "swr_decode", 4'd1, C_DECODE);
    step(0, "swr_memadr", 4'd2, C_MEMADR);
    mem_ready = 1'b0;
    step(0, "swr_stall1", 4'd5, C_MEMWR);
    step(0, "swr_stall2", 4'd5, C_MEMWR);
    rst[0] = 1'b1;
    step(0, "swr_reset", 4'd5, C_RESET);
    rst[0] = 1'b0;
    mem_ready = 1'b1;
    op = 6'b000010;
    step(0, "swr_after", 4'd0, C_FETCH_DONE);
    step(0, "swr_after_dec", 4'd1, C_DECODE);
    step(0, "swr_after_j", 4'd11, C_J);

    op = 6'b111111;
    step(0, "trap_fetch", 4'd0, C_FETCH_DONE);
    step(0, "trap_decode", 4'd1, C_DECODE);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      op = (i > 4) ? 6'b100011 : 6'b111111;
      step(0, "trap_hold", 4'd15, C_TRAP);
    end
    rst[0] = 1'b1;
    mem_ready = 1'b1;
    step(0, "trap_reset", 4'd15, C_RESET);
    rst[0] = 1'b0;
    op = 6'b000010;
    step(0, "trap_after", 4'd0, C_FETCH_DONE);

    // MEM_WAIT=2 instance
    rst[1] = 1'b0;
    op = 6'b001000;
    mem_ready = 1'b1;
    step(1, "w2_fetch1", 4'd0, C_FETCH_WAIT);
    step(1, "w2_fetch2", 4'd0, C_FETCH_WAIT);
    step(1, "w2_fetch3", 4'd0, C_FETCH_DONE);
    step(1, "w2_decode", 4'd1, C_DECODE);
    step(1, "w2_addiex", 4'd8, C_ADDIEX);
    step(1, "w2_addiwb", 4'd9, C_ADDIWB);
    op = 6'b100011;
    for (int i = 1; i <= 8; i++) begin
      mem_ready = (i <= 2) || (i == 8);
      step(1, "w2_fetch_stall", 4'd0, (i == 8) ? C_FETCH_DONE : C_FETCH_WAIT);
    end
    mem_ready = 1'b1;
    step(1, "w2_lw_decode", 4'd1, C_DECODE);
    step(1, "w2_lw_memadr", 4'd2, C_MEMADR);
    step(1, "w2_memrd1", 4'd3, C_MEMRD);
    step(1, "w2_memrd2", 4'd3, C_MEMRD);
    step(1, "w2_memrd3", 4'd3, C_MEMRD);
    step(1, "w2_memwb", 4'd4, C_MEMWB);
    step(1, "w2_next_fetch", 4'd0, C_FETCH_WAIT);

    // TRAP_EN=0 instance: unknown opcode retires as a NOP
    rst[2] = 1'b0;
    op = 6'b111111;
    step(2, "nt_fetch", 4'd0, C_FETCH_DONE);
    step(2, "nt_decode", 4'd1, C_DECODE);
    step(2, "nt_refetch", 4'd0, C_FETCH_DONE);
    step(2, "nt_decode2", 4'd1, C_DECODE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
